// File: rtl/procyon_rob_store_retire.sv
// ROB-side requester for store retirement.
// When the ROB head holds a completed store, this block sends a retire request
// and the latched tag to the store queue. It then waits for the OR-reduced ack,
// pops the ROB head for one cycle and counts the retired store.
// Optional watchdog: define PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN to enable
// o_timeout. It is a sticky flag raised after OPTN_TIMEOUT_CYCLES REQ cycles
// without an ack.

module procyon_rob_store_retire #(
  parameter int unsigned OPTN_ROB_IDX_WIDTH  = 5,
  parameter int unsigned OPTN_CNT_WIDTH      = 16,
  parameter int unsigned OPTN_TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          i_head_valid,
  input  logic                          i_head_rdy,
  input  logic                          i_head_is_store,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_head_tag,
  output logic                          o_rob_retire_en,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_rob_retire_tag,
  input  logic                          i_rob_retire_ack,
  output logic                          o_rob_pop,
  output logic                          o_busy,
  output logic [OPTN_CNT_WIDTH-1:0]     o_store_retire_count,
  output logic                          o_timeout
);

  // The watchdog needs a nonzero limit; a zero limit would flag on entry.
  if (OPTN_TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("OPTN_TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {StIdle, StReq, StPop} state_e;

  state_e                          state_q, state_d;
  logic [OPTN_ROB_IDX_WIDTH-1:0]   tag_q, tag_d;
  logic [OPTN_CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                            head_qualifies;
  logic                            start_req;

  // Only a completed, valid store at the head starts a retirement.
  // A flush in the same cycle suppresses it.
  assign head_qualifies = i_head_valid & i_head_rdy & i_head_is_store & ~i_flush;
  assign start_req      = (state_q == StIdle) & head_qualifies;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush beats ack in REQ; POP always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (head_qualifies) state_d = StReq;
      end
      StReq: begin
        if (i_flush) begin
          state_d = StIdle;
        end else if (i_rob_retire_ack) begin
          state_d = StPop;
        end
      end
      StPop:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    o_rob_retire_en  = 1'b0;
    o_rob_retire_tag = '0;
    o_rob_pop        = 1'b0;
    o_busy           = 1'b0;
    unique case (state_q)
      StReq: begin
        o_rob_retire_en  = 1'b1;
        o_rob_retire_tag = tag_q;
        o_busy           = 1'b1;
      end
      StPop: begin
        o_rob_pop = 1'b1;
        o_busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // Tag is captured once on entry to REQ, so head changes during the handshake are ignored
  always_comb begin
    tag_d = tag_q;
    cnt_d = cnt_q;
    if (start_req) tag_d = i_head_tag;
    if (state_q == StPop) cnt_d = cnt_q + OPTN_CNT_WIDTH'(1);
  end

  // Tag and retired-store counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_store_retire_count = cnt_q;

`ifdef PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(OPTN_TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(OPTN_TIMEOUT_CYCLES);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  // Wait counter saturates at the limit; timeout is sticky until reset
  always_comb begin
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (start_req) begin
      wait_d = '0;
    end else if ((state_q == StReq) && !i_rob_retire_ack && (wait_q != WaitLimit)) begin
      wait_d = wait_q + WaitW'(1);
    end
    if (wait_d == WaitLimit) timeout_d = 1'b1;
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_procyon_rob_store_retire.sv
// Self-checking bench for procyon_rob_store_retire.
// Two instances share the stimulus: the default configuration, and a narrow one
// with a 2-bit counter and an 8-cycle watchdog, which exercises wrap and timeout.

module tb_procyon_rob_store_retire;

  localparam int unsigned IW = 5;

  logic          clk;
  logic          rst;
  logic          i_flush;
  logic          i_head_valid;
  logic          i_head_rdy;
  logic          i_head_is_store;
  logic [IW-1:0] i_head_tag;
  logic          i_rob_retire_ack;

  logic          en, pop, busy, to;
  logic [IW-1:0] rtag;
  logic [15:0]   cnt;
  logic          en_w, pop_w, busy_w, to_w;
  logic [IW-1:0] rtag_w;
  logic [1:0]    cnt_w;

  procyon_rob_store_retire dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_flush              (i_flush),
    .i_head_valid         (i_head_valid),
    .i_head_rdy           (i_head_rdy),
    .i_head_is_store      (i_head_is_store),
    .i_head_tag           (i_head_tag),
    .o_rob_retire_en      (en),
    .o_rob_retire_tag     (rtag),
    .i_rob_retire_ack     (i_rob_retire_ack),
    .o_rob_pop            (pop),
    .o_busy               (busy),
    .o_store_retire_count (cnt),
    .o_timeout            (to)
  );

  procyon_rob_store_retire #(
    .OPTN_ROB_IDX_WIDTH  (IW),
    .OPTN_CNT_WIDTH      (2),
    .OPTN_TIMEOUT_CYCLES (8)
  ) dut_w (
    .clk                  (clk),
    .rst                  (rst),
    .i_flush              (i_flush),
    .i_head_valid         (i_head_valid),
    .i_head_rdy           (i_head_rdy),
    .i_head_is_store      (i_head_is_store),
    .i_head_tag           (i_head_tag),
    .o_rob_retire_en      (en_w),
    .o_rob_retire_tag     (rtag_w),
    .i_rob_retire_ack     (i_rob_retire_ack),
    .o_rob_pop            (pop_w),
    .o_busy               (busy_w),
    .o_store_retire_count (cnt_w),
    .o_timeout            (to_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an outstanding request, a pending pop, a tag and a running total
  bit          m_req, m_pop, m_to, m_to_w;
  logic [IW-1:0] m_tag;
  int unsigned m_cnt, m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                       input logic st, input logic [IW-1:0] tg, input logic ak);
    rst = r; i_flush = f; i_head_valid = v; i_head_rdy = rd;
    i_head_is_store = st; i_head_tag = tg; i_rob_retire_ack = ak;
  endtask

  // Model advance for one rising edge using the currently driven inputs
  task automatic model_step();
    if (rst) begin
      m_req = 0; m_pop = 0; m_tag = '0; m_cnt = 0; m_wait = 0; m_to = 0; m_to_w = 0;
    end else begin
`ifdef PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN
      if (m_req && !i_rob_retire_ack) begin
        m_wait++;
        if (m_wait >= 64) m_to = 1;
        if (m_wait >= 8) m_to_w = 1;
      end
`endif
      if (m_pop) begin
        m_pop = 0;
        m_cnt++;
      end else if (m_req) begin
        if (i_flush) m_req = 0;
        else if (i_rob_retire_ack) begin m_req = 0; m_pop = 1; end
      end else if (i_head_valid && i_head_rdy && i_head_is_store && !i_flush) begin
        m_req = 1; m_tag = i_head_tag; m_wait = 0;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare both instances against the model at the falling edge, then advance
  task automatic step(input string ctx);
    @(negedge clk);
    chk({ctx, ":en"}, {31'd0, en}, {31'd0, m_req});
    chk({ctx, ":pop"}, {31'd0, pop}, {31'd0, m_pop});
    chk({ctx, ":busy"}, {31'd0, busy}, {31'd0, m_req | m_pop});
    chk({ctx, ":cnt"}, {16'd0, cnt}, m_cnt & 32'hFFFF);
    chk({ctx, ":cnt_w"}, {30'd0, cnt_w}, m_cnt & 32'h3);
    chk({ctx, ":en_w"}, {31'd0, en_w}, {31'd0, m_req});
    chk({ctx, ":pop_w"}, {31'd0, pop_w}, {31'd0, m_pop});
    chk({ctx, ":to"}, {31'd0, to}, {31'd0, m_to});
    chk({ctx, ":to_w"}, {31'd0, to_w}, {31'd0, m_to_w});
    if (m_req) begin
      chk({ctx, ":tag"}, {27'd0, rtag}, {27'd0, m_tag});
      chk({ctx, ":tag_w"}, {27'd0, rtag_w}, {27'd0, m_tag});
    end
    advance();
  endtask

  typedef struct {
    logic          flush, valid, rdy, store;
    logic [IW-1:0] tag;
    logic          ack;
    logic          en;
    logic [IW-1:0] etag;
    logic          pop, busy;
    int unsigned   cnt;
  } vec_t;

  vec_t vt[24];
  int   wrap_seq[5];
  bit   to_en;

  initial begin
`ifdef PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN
    to_en = 1;
`else
    to_en = 0;
`endif
    wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3; wrap_seq[3] = 0; wrap_seq[4] = 1;

    // Rows: inputs applied this cycle, outputs expected in this cycle (count starts at 0)
    vt[0]  = '{0, 1, 1, 1, 5'd5, 0,  0, 5'd0, 0, 0, 0};  // basic: qualify tag 5
    vt[1]  = '{0, 0, 0, 0, 5'd0, 1,  1, 5'd5, 0, 1, 0};  // REQ, immediate ack
    vt[2]  = '{0, 0, 0, 0, 5'd0, 0,  0, 5'd0, 1, 1, 0};  // POP
    vt[3]  = '{0, 0, 0, 0, 5'd0, 0,  0, 5'd0, 0, 0, 1};
    vt[4]  = '{0, 1, 1, 1, 5'd3, 0,  0, 5'd0, 0, 0, 1};  // delayed ack: tag 3
    vt[5]  = '{0, 1, 1, 1, 5'd7, 0,  1, 5'd3, 0, 1, 1};  // head tag moves to 7
    vt[6]  = '{0, 1, 1, 1, 5'd7, 0,  1, 5'd3, 0, 1, 1};
    vt[7]  = '{0, 1, 1, 1, 5'd7, 0,  1, 5'd3, 0, 1, 1};
    vt[8]  = '{0, 1, 1, 1, 5'd7, 0,  1, 5'd3, 0, 1, 1};
    vt[9]  = '{0, 1, 1, 1, 5'd7, 1,  1, 5'd3, 0, 1, 1};  // 5th REQ cycle, ack
    vt[10] = '{0, 0, 0, 0, 5'd7, 0,  0, 5'd0, 1, 1, 1};
    vt[11] = '{0, 0, 0, 0, 5'd0, 0,  0, 5'd0, 0, 0, 2};
    vt[12] = '{0, 1, 1, 1, 5'd9, 0,  0, 5'd0, 0, 0, 2};  // flush: tag 9
    vt[13] = '{1, 0, 0, 0, 5'd9, 1,  1, 5'd9, 0, 1, 2};  // flush with ack wins
    vt[14] = '{0, 1, 1, 1, 5'd9, 0,  0, 5'd0, 0, 0, 2};  // IDLE, no pop
    vt[15] = '{0, 0, 0, 0, 5'd9, 1,  1, 5'd9, 0, 1, 2};
    vt[16] = '{1, 0, 0, 0, 5'd9, 0,  0, 5'd0, 1, 1, 2};  // flush in POP keeps pop
    vt[17] = '{0, 1, 1, 0, 5'd4, 1,  0, 5'd0, 0, 0, 3};  // non-store head x5
    vt[18] = '{0, 1, 1, 0, 5'd4, 1,  0, 5'd0, 0, 0, 3};
    vt[19] = '{0, 1, 1, 0, 5'd4, 1,  0, 5'd0, 0, 0, 3};
    vt[20] = '{0, 1, 1, 0, 5'd4, 1,  0, 5'd0, 0, 0, 3};
    vt[21] = '{0, 1, 1, 0, 5'd4, 1,  0, 5'd0, 0, 0, 3};
    vt[22] = '{1, 1, 1, 1, 5'd1, 0,  0, 5'd0, 0, 0, 3};  // flush blocks qualify
    vt[23] = '{0, 0, 0, 0, 5'd0, 0,  0, 5'd0, 0, 0, 3};

    drive(1, 0, 0, 0, 0, '0, 0);
    #1;
    advance();
    advance();
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("rst:en", {31'd0, en}, 0);
    chk("rst:pop", {31'd0, pop}, 0);
    chk("rst:busy", {31'd0, busy}, 0);
    chk("rst:cnt", {16'd0, cnt}, 0);
    chk("rst:to", {31'd0, to}, 0);
    for (int i = 0; i < 10; i++) step("idle");

    // Table-driven directed vectors
    for (int i = 0; i < 24; i++) begin
      drive(0, vt[i].flush, vt[i].valid, vt[i].rdy, vt[i].store, vt[i].tag, vt[i].ack);
      @(negedge clk);
      chk($sformatf("vec%0d:en", i), {31'd0, en}, {31'd0, vt[i].en});
      chk($sformatf("vec%0d:pop", i), {31'd0, pop}, {31'd0, vt[i].pop});
      chk($sformatf("vec%0d:busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      chk($sformatf("vec%0d:cnt", i), {16'd0, cnt}, vt[i].cnt);
      chk($sformatf("vec%0d:cnt_w", i), {30'd0, cnt_w}, vt[i].cnt % 4);
      if (vt[i].en) chk($sformatf("vec%0d:tag", i), {27'd0, rtag}, {27'd0, vt[i].etag});
      advance();
    end

    // Back-to-back retires on the 2-bit counter: 1,2,3,0,1
    drive(1, 0, 0, 0, 0, '0, 0);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 1, 1, IW'(k + 10), 0);
      step("wrap_q");
      drive(0, 0, 0, 0, 0, '0, 1);
      step("wrap_r");
      drive(0, 0, 1, 1, 1, '0, 0);
      step("wrap_p");
      chk($sformatf("wrap%0d:cnt_w", k), {30'd0, cnt_w}, wrap_seq[k]);
    end

    // Reset while a request is outstanding
    drive(0, 0, 1, 1, 1, 5'd6, 0);
    step("rreq_q");
    drive(1, 0, 0, 0, 0, '0, 0);
    step("rreq_r");
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("rreq:en", {31'd0, en}, 0);
    chk("rreq:cnt", {16'd0, cnt}, 0);
    step("rreq_idle");

    // Ack withheld: the narrow watchdog fires after 8 REQ cycles only when enabled
    drive(0, 0, 1, 1, 1, 5'd2, 0);
    step("wd_q");
    drive(0, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step("wd_req");
    chk("wd:to_w", {31'd0, to_w}, {31'd0, to_en});
    chk("wd:to", {31'd0, to}, 0);
    chk("wd:en_w", {31'd0, en_w}, 1);
    for (int i = 0; i < 3; i++) step("wd_hold");
    drive(0, 0, 0, 0, 0, '0, 1);
    step("wd_ack");
    drive(0, 0, 0, 0, 0, '0, 0);
    step("wd_pop");
    chk("wd_sticky:to_w", {31'd0, to_w}, {31'd0, to_en});
    drive(1, 0, 0, 0, 0, '0, 0);
    step("wd_rst");
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("wd_clr:to_w", {31'd0, to_w}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            IW'($urandom),
            $urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/procyon_rob_store_retire.md
Name: procyon_rob_store_retire

Overview:
- Requester side of the ROB-to-SQ store retirement handshake.
- Sits at the ROB head. When the head op is a store that has completed, it drives a retire request and tag to all SQ entries and waits for the OR-reduced ack.
- On ack it pops the ROB head and counts the retired store.
- Non-store head ops are not handled by this block; ROB gating logic ignores o_rob_pop unless o_busy is high.

Parameters:
- OPTN_ROB_IDX_WIDTH, 5: width of ROB tag.
- OPTN_CNT_WIDTH, 16: width of the retired-store counter.
- OPTN_TIMEOUT_CYCLES, 64: watchdog limit in cycles. Used only when PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_flush  input  1  pipeline flush.
- i_head_valid  input  1  ROB head holds a valid op.
- i_head_rdy  input  1  ROB head op has completed execution.
- i_head_is_store  input  1  ROB head op is SB/SH/SW.
- i_head_tag  input  OPTN_ROB_IDX_WIDTH  ROB index of the head.
- o_rob_retire_en  output  1  retire request to SQ.
- o_rob_retire_tag  output  OPTN_ROB_IDX_WIDTH  tag of the store being retired.
- i_rob_retire_ack  input  1  OR of all SQ entry acks; combinational response to the request.
- o_rob_pop  output  1  one-cycle pulse: ROB head store retired.
- o_busy  output  1  a store retirement is in progress.
- o_store_retire_count  output  OPTN_CNT_WIDTH  number of stores retired.
- o_timeout  output  1  sticky watchdog error (macro only).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, tag register=0, counter=0, timeout counter=0, o_timeout=0. All outputs 0 on the following cycle.
- States: IDLE, REQ, POP.
- IDLE:
  - If i_head_valid & i_head_rdy & i_head_is_store & ~i_flush, latch i_head_tag and go to REQ.
  - Otherwise stay in IDLE.
  - Outputs o_rob_retire_en=0, o_busy=0.
- REQ:
  - o_rob_retire_en=1, o_rob_retire_tag=latched tag, o_busy=1.
  - If i_flush, go to IDLE with no pop; flush wins even if ack is high in the same cycle.
  - Else if i_rob_retire_ack, go to POP.
  - Else stay in REQ; the request is held stable until ack or flush.
- POP:
  - o_rob_pop=1 for exactly this cycle, o_busy=1, o_rob_retire_en=0.
  - Counter increments by 1, modulo 2^OPTN_CNT_WIDTH; all-ones wraps to 0.
  - Next state is IDLE unconditionally. The pop is not cancelled by i_flush in this cycle, because the SQ entry has already moved to nonspeculative.
- Latency: head qualifies at cycle N → request at N+1 → ack at N+1 (best case) → pop at N+2 → IDLE at N+3. The next head is evaluated at N+3, because the ROB head pointer updates on the pop edge.
- o_rob_retire_tag is the latched value, not i_head_tag; changes on i_head_tag while in REQ are ignored.
- Head inputs in REQ/POP are don't-care, except that i_flush matters in REQ.
- Never more than one outstanding request; o_rob_pop never asserts in two consecutive cycles.
- Reset asserted mid-REQ: the request drops on the next cycle and the counter clears.

Optional Feature:
- Macro: PROCYON_ROB_STORE_RETIRE_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and increments each cycle spent in REQ without ack.
  - When it reaches OPTN_TIMEOUT_CYCLES, o_timeout sets and stays set until rst.
  - The FSM is unaffected and keeps requesting.
- Undefined: no counter logic; o_timeout is tied to 0.

Test Plan:
- Reset then idle: hold rst 2 cycles, release → all outputs 0 and count=0 for 10 cycles with i_head_valid=0.
- Basic retire: head valid/rdy/store, tag=5, ack returned immediately while o_rob_retire_en=1 → o_rob_retire_en=1 with tag=5 for 1 cycle; o_rob_pop=1 the next cycle; count=1.
- Delayed ack with tag change: tag=3, ack withheld 4 cycles, i_head_tag driven to 7 meanwhile → request held 5 cycles with tag=3; single pop; count=1.
- Flush in REQ: tag=9, assert i_flush together with ack on the first REQ cycle → no pop, IDLE next cycle, count unchanged. Flush during POP → pop still asserted.
- Non-store head: i_head_is_store=0, valid/rdy=1 for 5 cycles → o_rob_retire_en=0 and o_rob_pop=0 throughout.
- Wrap and watchdog: OPTN_CNT_WIDTH=2, 5 back-to-back retires → count sequence 1,2,3,0,1. With macro defined and OPTN_TIMEOUT_CYCLES=8, ack never returned → o_timeout=1 after 8 REQ cycles and stays set until rst.
